// File: rtl/lpf_pkg.sv
// Shared definitions for the low-pass FIR output stages.
// Holds the default widths, the output sample type and a
// round-and-saturate helper for any stage that narrows the full-precision
// FIR accumulator to an output sample at the default widths.
package lpf_pkg;

   localparam int unsigned L_ACC_LEN_DEFAULT    = 36;
   localparam int unsigned L_OUT_LEN_DEFAULT    = 16;
   localparam int unsigned L_FRAC_SHIFT_DEFAULT = 15;
   localparam int unsigned L_DECIM_W_DEFAULT    = 8;
   localparam int unsigned L_FIFO_DEPTH_DEFAULT = 4;

   typedef logic signed [L_OUT_LEN_DEFAULT-1:0] sample_t;

   // One extra bit so adding the rounding constant can never wrap.
   localparam int unsigned L_SUM_LEN = L_ACC_LEN_DEFAULT + 1;
   localparam int unsigned L_RND_LEN = L_SUM_LEN - L_FRAC_SHIFT_DEFAULT;

   localparam sample_t L_OUT_MAX = {1'b0, {(L_OUT_LEN_DEFAULT-1){1'b1}}};
   localparam sample_t L_OUT_MIN = {1'b1, {(L_OUT_LEN_DEFAULT-1){1'b0}}};

   // Round half toward +inf, then clamp to the sample range.
   function automatic sample_t sat_round(input logic signed [L_ACC_LEN_DEFAULT-1:0] acc);
      logic signed [L_SUM_LEN-1:0] sum;
      logic signed [L_RND_LEN-1:0] r;
      logic signed [L_RND_LEN-1:0] r_max;
      logic signed [L_RND_LEN-1:0] r_min;
      r_max = L_RND_LEN'(L_OUT_MAX);
      r_min = L_RND_LEN'(L_OUT_MIN);
      sum   = $signed({acc[L_ACC_LEN_DEFAULT-1], acc})
            + $signed(L_SUM_LEN'(1) << (L_FRAC_SHIFT_DEFAULT - 1));
      r     = L_RND_LEN'(sum >>> L_FRAC_SHIFT_DEFAULT);
      if (r > r_max) begin
         return L_OUT_MAX;
      end else if (r < r_min) begin
         return L_OUT_MIN;
      end
      return r[L_OUT_LEN_DEFAULT-1:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush_i          synchronous clear of all entries (wins over push/pop)
//   push_i, wdata_i  write request and data; accepted when not full, or when
//                    full and a pop happens in the same cycle
//   pop_i            remove the head entry (ignored when empty)
//   rdata_o          head entry, zero while empty
//   full_o, empty_o  occupancy flags
module sync_fifo
   import lpf_pkg::*;
#(
   parameter int unsigned WIDTH = L_OUT_LEN_DEFAULT,
   parameter int unsigned DEPTH = L_FIFO_DEPTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: rdata_o is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/lpf_decim.sv
// Decimating output stage behind the low-pass FIR.
// Keeps every Dth valid accumulator sample, rounds (half toward +inf) and
// saturates it to OUT_LEN bits over two pipeline stages, and queues results
// in a FWFT FIFO with a valid/ready output.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   acc_i, acc_valid_i    full-precision FIR sample and its strobe
//   decim_i               decimation factor (0 behaves as 1)
//   clr_i                 synchronous flush of phase, pipeline, FIFO, flags
//   data_o, valid_o       FIFO head and its valid
//   ready_i               consumer accept
//   ovf_o                 sticky: a kept sample was dropped on a full FIFO
//   sat_o                 sticky: a kept sample was clamped
module lpf_decim
   import lpf_pkg::*;
#(
   parameter int unsigned ACC_LEN    = L_ACC_LEN_DEFAULT,
   parameter int unsigned OUT_LEN    = L_OUT_LEN_DEFAULT,
   parameter int unsigned FRAC_SHIFT = L_FRAC_SHIFT_DEFAULT,
   parameter int unsigned DECIM_W    = L_DECIM_W_DEFAULT,
   parameter int unsigned FIFO_DEPTH = L_FIFO_DEPTH_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic signed [ACC_LEN-1:0] acc_i,
   input  logic                      acc_valid_i,
   input  logic        [DECIM_W-1:0] decim_i,
   input  logic                      clr_i,
   output logic signed [OUT_LEN-1:0] data_o,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic                      ovf_o,
   output logic                      sat_o
);

   localparam int unsigned SUM_LEN = ACC_LEN + 1;
   localparam int unsigned RND_LEN = SUM_LEN - FRAC_SHIFT;

   localparam logic signed [OUT_LEN-1:0] OUT_MAX = {1'b0, {(OUT_LEN-1){1'b1}}};
   localparam logic signed [OUT_LEN-1:0] OUT_MIN = {1'b1, {(OUT_LEN-1){1'b0}}};
   localparam logic signed [RND_LEN-1:0] RND_MAX = RND_LEN'(OUT_MAX);
   localparam logic signed [RND_LEN-1:0] RND_MIN = RND_LEN'(OUT_MIN);
   localparam logic signed [SUM_LEN-1:0] HALF    = SUM_LEN'(1) << (FRAC_SHIFT - 1);

   // ---------------- phase counter ----------------
   logic [DECIM_W-1:0] phase_q, phase_d;
   logic [DECIM_W-1:0] dlat_q, dlat_d;
   logic [DECIM_W-1:0] decim_eff, d_cur;
   logic               load_q;
   logic               keep;

   assign decim_eff = (decim_i == '0) ? DECIM_W'(1) : decim_i;
   // Right after reset/clear the factor has not been latched yet, so the
   // live input stands in for it on that first edge.
   assign d_cur     = load_q ? decim_eff : dlat_q;
   assign keep      = acc_valid_i && (phase_q == '0);

   always_comb begin
      phase_d = phase_q;
      dlat_d  = d_cur;
      if (acc_valid_i) begin
         if (phase_q >= d_cur - DECIM_W'(1)) begin
            phase_d = '0;
            dlat_d  = decim_eff;
         end else begin
            phase_d = phase_q + DECIM_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
         dlat_q  <= DECIM_W'(1);
         load_q  <= 1'b1;
      end else if (clr_i) begin
         phase_q <= '0;
         dlat_q  <= DECIM_W'(1);
         load_q  <= 1'b1;
      end else begin
         phase_q <= phase_d;
         dlat_q  <= dlat_d;
         load_q  <= 1'b0;
      end
   end

   // ---------------- stage 1: round ----------------
   logic signed [SUM_LEN-1:0] sum;
   logic signed [RND_LEN-1:0] r1_d, r1_q;
   logic                      v1_q;

   assign sum  = $signed({acc_i[ACC_LEN-1], acc_i}) + HALF;
   assign r1_d = RND_LEN'(sum >>> FRAC_SHIFT);

   // ---------------- stage 2: saturate ----------------
   logic                      hi, lo;
   logic signed [OUT_LEN-1:0] s2_d, s2_q;
   logic                      v2_q;

   assign hi   = (r1_q > RND_MAX);
   assign lo   = (r1_q < RND_MIN);
   assign s2_d = hi ? OUT_MAX : (lo ? OUT_MIN : r1_q[OUT_LEN-1:0]);

   // ---------------- FIFO write ----------------
   logic fifo_full, fifo_empty, pop, push, drop;
   logic sat_q, ovf_q;

   assign valid_o = !fifo_empty;
   assign pop     = valid_o && ready_i;
   assign push    = v2_q && (!fifo_full || pop);
   assign drop    = v2_q && fifo_full && !pop;
   assign sat_o   = sat_q;
   assign ovf_o   = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_q  <= '0;
         v1_q  <= 1'b0;
         s2_q  <= '0;
         v2_q  <= 1'b0;
         sat_q <= 1'b0;
         ovf_q <= 1'b0;
      end else if (clr_i) begin
         r1_q  <= '0;
         v1_q  <= 1'b0;
         s2_q  <= '0;
         v2_q  <= 1'b0;
         sat_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         v1_q <= keep;
         if (keep) r1_q <= r1_d;
         v2_q <= v1_q;
         if (v1_q) s2_q <= s2_d;
         sat_q <= sat_q | (v1_q & (hi | lo));
         ovf_q <= ovf_q | drop;
      end
   end

   sync_fifo #(
      .WIDTH (OUT_LEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (clr_i),
      .push_i  (push),
      .wdata_i (s2_q),
      .pop_i   (pop),
      .rdata_o (data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_lpf_decim.sv
// Self-checking bench for lpf_decim: directed table, hand sequences for the
// multi-cycle corners, and a randomized run, all checked every cycle against
// an event-based reference model (queue FIFO, arithmetic rounding).
module tb_lpf_decim;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [35:0] acc_i = '0;
   logic               acc_valid_i = 1'b0;
   logic        [7:0]  decim_i = 8'd1;
   logic               clr_i = 1'b0;
   logic signed [15:0] data_o;
   logic               valid_o;
   logic               ready_i = 1'b1;
   logic               ovf_o;
   logic               sat_o;

   lpf_decim dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .acc_i       (acc_i),
      .acc_valid_i (acc_valid_i),
      .decim_i     (decim_i),
      .clr_i       (clr_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .ovf_o       (ovf_o),
      .sat_o       (sat_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int     sat_due;
      int     fifo_due;
      longint val;
      bit     sat;
   } pend_t;

   pend_t  pend[$];
   longint mq[$];
   longint got[$];
   bit     m_ovf, m_sat, m_first;
   int     m_cnt, m_dlat, cyc;

   function automatic int eff_d(input logic [7:0] d);
      return (d == 8'd0) ? 1 : int'(d);
   endfunction

   // floor((a + 2^14) / 2^15), clamped to 16-bit signed
   task automatic ref_round(input longint a, output longint r, output bit s);
      longint v;
      v = a + 16384;
      if (v >= 0) r = v / 32768;
      else        r = -((-v + 32767) / 32768);
      s = 1'b0;
      if (r > 32767) begin
         r = 32767;
         s = 1'b1;
      end else if (r < -32768) begin
         r = -32768;
         s = 1'b1;
      end
   endtask

   function automatic void model_clear();
      pend.delete();
      mq.delete();
      m_ovf   = 1'b0;
      m_sat   = 1'b0;
      m_first = 1'b1;
      m_cnt   = 0;
      m_dlat  = 1;
   endfunction

   // Advance the model across one clock edge using the current inputs.
   task automatic model_edge();
      longint r;
      bit     s;
      if (clr_i) begin
         model_clear();
         cyc++;
         return;
      end
      if (m_first) begin
         m_dlat  = eff_d(decim_i);
         m_first = 1'b0;
      end
      if (ready_i && mq.size() > 0) void'(mq.pop_front());
      foreach (pend[i]) if (pend[i].sat_due == cyc && pend[i].sat) m_sat = 1'b1;
      if (pend.size() > 0 && pend[0].fifo_due == cyc) begin
         pend_t e;
         e = pend.pop_front();
         if (mq.size() < 4) mq.push_back(e.val);
         else               m_ovf = 1'b1;
      end
      if (acc_valid_i) begin
         if (m_cnt == 0) begin
            ref_round(longint'(acc_i), r, s);
            pend.push_back('{cyc + 1, cyc + 2, r, s});
         end
         m_cnt++;
         if (m_cnt >= m_dlat) begin
            m_cnt  = 0;
            m_dlat = eff_d(decim_i);
         end
      end
      cyc++;
   endtask

   task automatic tick();
      bit     pop_now;
      longint pv;
      pop_now = valid_o && ready_i;
      pv      = longint'(data_o);
      model_edge();
      @(posedge clk);
      #1;
      if (pop_now) got.push_back(pv);
      check("valid_o", longint'(valid_o), longint'(mq.size() > 0));
      if (mq.size() > 0) check("data_o", longint'(data_o), mq[0]);
      check("ovf_o", longint'(ovf_o), longint'(m_ovf));
      check("sat_o", longint'(sat_o), longint'(m_sat));
   endtask

   task automatic drive(input longint a, input bit v);
      acc_i       = a[35:0];
      acc_valid_i = v;
   endtask

   task automatic idle(input int n);
      drive(0, 1'b0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_clr();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      got.delete();
      check("clr valid_o", longint'(valid_o), 0);
      check("clr ovf_o", longint'(ovf_o), 0);
      check("clr sat_o", longint'(sat_o), 0);
   endtask

   // Asserted between edges; outputs must clear immediately.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst data_o", longint'(data_o), 0);
      check("rst valid_o", longint'(valid_o), 0);
      check("rst ovf_o", longint'(ovf_o), 0);
      check("rst sat_o", longint'(sat_o), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      got.delete();
   endtask

   task automatic expect_got(input string name, input longint exp[$]);
      check({name, " count"}, longint'(got.size()), longint'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         check(name, (i < got.size()) ? got[i] : 64'sh7fff_ffff, exp[i]);
      end
   endtask

   function automatic longint rand_acc();
      longint t;
      case ($urandom_range(0, 3))
         0: t = longint'($signed($urandom)) >>> 6;
         1: t = longint'($signed($urandom));
         2: begin
            t = {$urandom, $urandom};
            t = (t <<< 28) >>> 28;
         end
         default: begin
            if ($urandom_range(0, 1) == 1) t = 64'sd32767 * 32768 + 16383;
            else                           t = -64'sd32768 * 32768 - 16384;
            t = t + longint'($urandom_range(0, 4)) - 2;
         end
      endcase
      return t;
   endfunction

   typedef struct {
      longint acc;
      bit     v;
      bit     exp_v;
      longint exp_d;
   } vec_t;

   vec_t   tbl[7];
   longint e[$];

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{32768,   1'b1, 1'b0, 0};
      tbl[1] = '{114688,  1'b1, 1'b0, 0};
      tbl[2] = '{-16384,  1'b1, 1'b1, 1};
      tbl[3] = '{-16385,  1'b1, 1'b1, 4};
      tbl[4] = '{0,       1'b0, 1'b1, 0};
      tbl[5] = '{0,       1'b0, 1'b1, -1};
      tbl[6] = '{0,       1'b0, 1'b0, 0};

      @(posedge clk);
      #1;
      do_reset();

      // D=1 rounding and 3-cycle latency
      decim_i = 8'd1;
      ready_i = 1'b1;
      do_clr();
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].acc, tbl[i].v);
         tick();
         check("tbl valid_o", longint'(valid_o), longint'(tbl[i].exp_v));
         if (tbl[i].exp_v) check("tbl data_o", longint'(data_o), tbl[i].exp_d);
      end

      // D=4 ramp: keeps 0,4,8,12
      decim_i = 8'd4;
      do_clr();
      for (int k = 0; k < 16; k++) begin
         drive(longint'(k) * 32768, 1'b1);
         tick();
      end
      idle(6);
      e = '{0, 4, 8, 12};
      expect_got("ramp", e);

      // saturation, sticky until clear
      decim_i = 8'd1;
      do_clr();
      drive(64'sd2147483648, 1'b1);
      tick();
      drive(-64'sd2147483648, 1'b1);
      tick();
      idle(4);
      e = '{32767, -32768};
      expect_got("sat", e);
      idle(10);
      check("sat held", longint'(sat_o), 1);
      do_clr();

      // overflow: 6 into a 4-deep FIFO with no consumer
      ready_i = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         drive(longint'(k) * 32768, 1'b1);
         tick();
      end
      idle(4);
      check("ovf set", longint'(ovf_o), 1);
      check("ovf head", longint'(data_o), 1);
      ready_i = 1'b1;
      got.delete();
      idle(8);
      e = '{1, 2, 3, 4};
      expect_got("ovf drain", e);
      check("ovf drained", longint'(valid_o), 0);

      // full FIFO with a pop and a push on the same edge
      do_clr();
      ready_i = 1'b0;
      for (int k = 10; k <= 14; k++) begin
         drive(longint'(k) * 32768, 1'b1);
         tick();
      end
      idle(1);
      ready_i = 1'b1;
      idle(8);
      check("full+pop ovf", longint'(ovf_o), 0);
      e = '{10, 11, 12, 13, 14};
      expect_got("full+pop", e);

      // factor change mid-period applies at the next wrap
      decim_i = 8'd4;
      do_clr();
      for (int k = 0; k < 10; k++) begin
         if (k == 2) decim_i = 8'd2;
         drive(longint'(k) * 32768, 1'b1);
         tick();
      end
      idle(5);
      e = '{0, 4, 6, 8};
      expect_got("decim chg", e);

      // clear mid-stream with both sticky flags set
      ready_i = 1'b0;
      decim_i = 8'd1;
      for (int k = 0; k < 12; k++) begin
         drive(64'sd8589934592, 1'b1);
         tick();
      end
      check("pre-clr ovf", longint'(ovf_o), 1);
      check("pre-clr sat", longint'(sat_o), 1);
      do_clr();
      drive(7 * 32768, 1'b1);
      tick();
      idle(2);
      check("post-clr kept", longint'(valid_o), 1);
      check("post-clr data", longint'(data_o), 7);

      // randomized run with clears and one asynchronous reset
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) == 0) decim_i = 8'($urandom_range(0, 5));
         if (c % 400 == 0) ready_i = ($urandom_range(0, 1) == 1);
         clr_i = ($urandom_range(0, 299) == 0);
         drive(rand_acc(), ($urandom_range(0, 3) != 0));
         if (c % 400 >= 200) ready_i = ($urandom_range(0, 2) != 0);
         if (c == 1500) begin
            clr_i = 1'b0;
            do_reset();
         end
         tick();
      end
      clr_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lpf_decim.md
Name: lpf_decim

Overview:
- Downstream stage of the low-pass FIR. Consumes the FIR's full-precision accumulated output stream and keeps every Dth sample (runtime decimation factor D).
- Rounds and saturates each kept sample to the output sample width.
- Buffers results in a small FIFO behind a valid/ready interface, so downstream consumers can apply backpressure while the FIR free-runs.

Parameters:
- ACC_LEN, 36, width of the signed FIR accumulator input (32-bit product + log2(16 taps)).
- OUT_LEN, 16, width of the signed output sample.
- FRAC_SHIFT, 15, number of fractional bits removed by rounding (Q15 coefficients).
- DECIM_W, 8, width of the decimation factor.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- acc_i  in  ACC_LEN  signed FIR output sample.
- acc_valid_i  in  1  acc_i is valid this cycle (no upstream ready; FIR never stalls).
- decim_i  in  DECIM_W  decimation factor D; 0 is treated as 1.
- clr_i  in  1  synchronous flush: clears pipeline, FIFO, phase and sticky flags.
- data_o  out  OUT_LEN  signed decimated sample, FIFO head.
- valid_o  out  1  data_o valid.
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i.
- ovf_o  out  1  sticky: a kept sample was dropped because the FIFO was full.
- sat_o  out  1  sticky: at least one sample saturated.

Behaviour:
- Reset: phase=0, pipeline valids=0, FIFO empty, data_o=0, valid_o=0, ovf_o=0, sat_o=0. clr_i has the same effect synchronously; clr_i overrides every other event in the same cycle.
- Phase counter: increments on each acc_valid_i and wraps at D_latched-1. A sample is kept when acc_valid_i is high and phase==0. The first valid after reset or clr_i is kept.
- D_latched: loads decim_i (0 maps to 1) at reset release and on each wrap to phase 0. A decim_i change mid-period takes effect at the next wrap.
- Stage 1 (edge 1):
  - r = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, i.e. round half toward +inf.
  - The computation is done at ACC_LEN+1 bits, so the add cannot wrap.
- Stage 2 (edge 2):
  - If r > 2^(OUT_LEN-1)-1, output 0x7FFF (for OUT_LEN=16) and set sat_o.
  - If r < -2^(OUT_LEN-1), output 0x8000 and set sat_o.
  - Otherwise output r truncated to OUT_LEN bits.
- FIFO write (edge 3):
  - The stage-2 result is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the sample is discarded and ovf_o is set; FIFO contents are unchanged.
- FIFO is first-word-fall-through. Latency from a kept acc_i (cycle 0) to valid_o, with the FIFO empty, is 3 cycles: valid_o rises after edge 3.
- Pop occurs on valid_o && ready_i. data_o and valid_o must not change while valid_o && !ready_i.
- Simultaneous push and pop when empty: not possible (valid_o=0). Simultaneous push and pop otherwise: occupancy unchanged.
- Throughput: one kept sample per cycle is sustainable with D=1 and ready_i=1.
- Asynchronous reset mid-operation discards all in-flight samples with no partial output.

Decomposition:
- Package lpf_pkg:
  - Constants: L_ACC_LEN_DEFAULT, L_OUT_LEN_DEFAULT, L_FRAC_SHIFT_DEFAULT.
  - Function sat_round(acc) for reuse by other FIR output stages.
  - Typedef sample_t (signed OUT_LEN).
- Sub-module sync_fifo (parameterised width/depth, FWFT, full/empty flags, same clk/rst_n), instantiated once. Phase counter, round and saturate stages stay in lpf_decim.

Test Plan:
- D=1, FRAC_SHIFT=15, acc_i = 32768, 114688, -16384, -16385 on consecutive cycles, ready_i=1 -> data_o = 1, 4, 0, -1; valid_o first rises 3 cycles after the first input.
- D=4, acc_i ramp 0,32768,65536,... (k*2^15) for 16 cycles -> outputs 0,4,8,12; exactly 4 valid_o pulses.
- acc_i = 2^31 then -2^31 -> data_o = 0x7FFF then 0x8000; sat_o=1 and held until clr_i.
- D=1, ready_i=0, 6 consecutive valids -> FIFO holds the first 4 (in order); ovf_o=1. Then ready_i=1 -> exactly 4 pops, then valid_o=0.
- FIFO full with ready_i=1 and a kept sample arriving the same cycle -> no drop, ovf_o stays 0, order preserved.
- decim_i changed 4->2 at phase 2, then clr_i mid-stream -> change applies at the next wrap. On clr_i, valid_o, ovf_o and sat_o go to 0 the next cycle and the next valid input is kept.
